axis_pkt_rr_arbiter: RTL
========================

Name: axis_pkt_rr_arbiter

Overview:
Packet-granular round-robin arbiter that shares one AXI-Stream sink between NUM_SRC requesting sources. A typical sink is the axis_data_fifo_0 input.
- Grant is locked from the first beat of a packet until its tlast beat is accepted, so packets never interleave.
- It sits directly upstream of the FIFO slave port. It sequences all producers onto that single 32-bit stream.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DATA_W, 32, tdata width in bits
KEEP_W, DATA_W/8, tkeep width
SID_W, 2, width of grant index; must be >= clog2(NUM_SRC)

Ports:
s_axis_aclk  in  1  clock
s_axis_aresetn  in  1  reset, asynchronous, active-low
s_axis_tvalid  in  NUM_SRC  per-source valid
s_axis_tdata  in  NUM_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
s_axis_tkeep  in  NUM_SRC*KEEP_W  per-source keep
s_axis_tlast  in  NUM_SRC  per-source last
s_axis_tready  out  NUM_SRC  per-source ready
m_axis_tvalid  out  1  to FIFO
m_axis_tdata  out  DATA_W  to FIFO
m_axis_tkeep  out  KEEP_W  to FIFO
m_axis_tlast  out  1  to FIFO
m_axis_tready  in  1  from FIFO
grant_id  out  SID_W  index of current/last granted source
busy  out  1  high while in XFER

Behaviour:
Reset is asynchronous, active-low, on s_axis_aresetn. Clock is s_axis_aclk. Reset values:
- state=IDLE, grant_id=0, busy=0.
- rr_ptr=NUM_SRC-1, so source 0 has first priority.
- All outputs 0 (m_axis_tvalid=0, s_axis_tready=0).

States:
- IDLE: m_axis_tvalid=0 and all s_axis_tready=0.
  - Each cycle, pick the first source with tvalid=1, searching from rr_ptr+1 modulo NUM_SRC upward.
  - If one is found: register grant_id, set busy=1, go to XFER next cycle.
  - If none: stay in IDLE.
- XFER: combinational pass-through from the granted source g.
  - m_axis_tvalid=s_axis_tvalid[g]; m_axis_tdata/tkeep/tlast come from slice g.
  - s_axis_tready[g]=m_axis_tready; all other s_axis_tready=0.
  - Zero-cycle datapath latency.
  - On a beat accepted with tlast (m_axis_tvalid & m_axis_tready & m_axis_tlast): rr_ptr<=g, busy<=0, go to IDLE.

Timing:
- Exactly one dead cycle between consecutive packets (the IDLE arbitration cycle).
- Peak throughput is L/(L+1) for L-beat packets.

Boundary conditions:
- Granted source drops tvalid mid-packet: grant is held indefinitely and m_axis_tvalid follows it. No timeout.
- m_axis_tready low (FIFO full): the granted source is stalled, tdata is held by the source (AXI rule), and the grant does not change.
- Single-beat packet (tlast on the first beat): accepted in one XFER cycle, then IDLE.
- Other sources asserting tvalid during XFER: ignored until the next IDLE.
- Only one requester: it is re-granted after each one-cycle IDLE gap.
- Reset asserted mid-packet: immediate return to the reset state. The partial packet is truncated at the FIFO; the FIFO shares the same reset, so it is cleared too.
- tvalid from a source is never used to change state except in IDLE.

Optional Feature:
Macro ARB_STATS_EN.
- Defined:
  - Adds output pkt_cnt (NUM_SRC*16 bits).
  - One 16-bit saturating counter per source, incremented on each accepted tlast beat of that source.
  - Saturates at 16'hFFFF; reset to 0.
  - Adds output beat_stall (1 bit): registered, high the cycle after any cycle with m_axis_tvalid=1 and m_axis_tready=0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package axis_arb_pkg holds:
  - the state encoding (IDLE=1'b0, XFER=1'b1);
  - the constant STAT_W=16;
  - a function for rotating-index wrap (ptr+1 mod NUM_SRC).
- One natural sub-module: rr_priority_pick. It is combinational; it takes req[NUM_SRC] and ptr[SID_W] and returns found and idx[SID_W]. It is reusable by other schedulers.

Test Plan:
- Reset, then src0 sends a 26-beat packet (tdata 0..25, tkeep=4'hF) with m_axis_tready=1 → 26 contiguous beats on m_axis with tlast on tdata=25; grant_id=0; busy falls on the cycle after tlast.
- All 4 sources continuously request 3-beat packets with m_axis_tready=1 → grant order 0,1,2,3,0,…; exactly 1 idle cycle between packets; no interleaved beats.
- Same traffic, but m_axis_tready toggles 1-in-4 (0001 rotating pattern) → every source beat is delivered once, in order; grant never changes mid-packet; s_axis_tready is only ever high for grant_id.
- src2 deasserts tvalid for 5 cycles mid-packet while src1 requests → m_axis_tvalid=0 for those 5 cycles; grant stays 2; src1 is granted only after src2's tlast.
- Reset pulsed low for 1 cycle during beat 10 of a src3 packet → all outputs 0 immediately; after release, src0 (if requesting) is granted first.
- With ARB_STATS_EN: src1 sends 70000 single-beat packets → pkt_cnt[31:16]=16'hFFFF (saturated), and all other counters are 0.

Source files
------------

// File: rtl/axis_pkt_rr_arbiter_pkg.sv
// Shared types and helpers for the packet round-robin arbiter and its priority picker.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  // Next index after ptr on a ring of n entries.
  function automatic int unsigned rr_wrap_inc(input int unsigned ptr, input int unsigned n);
    if (ptr + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first asserted req at or after ptr+1 (mod NUM_SRC).
module rr_priority_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SID_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SID_W-1:0]   ptr,
  output logic               found,
  output logic [SID_W-1:0]   idx
);

  int unsigned      start_s;
  logic             hi_found_s;
  logic             lo_found_s;
  logic [SID_W-1:0] hi_idx_s;
  logic [SID_W-1:0] lo_idx_s;

  // Split the ring at start: the lowest requester at/above start wins, else the lowest below it.
  always_comb begin
    start_s    = rr_wrap_inc(32'(ptr), NUM_SRC);
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i] && ($unsigned(i) >= start_s)) begin
        hi_found_s = 1'b1;
        hi_idx_s   = SID_W'(i);
      end else if (req[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = SID_W'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
    end
    found = hi_found_s | lo_found_s;
    if (hi_found_s) begin
      idx = hi_idx_s;
    end else begin
      idx = lo_idx_s;
    end
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter; grant held from first beat to accepted tlast.
// Optional per-source packet counters and stall flag are built when ARB_STATS_EN is defined.
module axis_pkt_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int SID_W   = 2
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_aresetn,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [KEEP_W-1:0]         m_axis_tkeep,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [SID_W-1:0]          grant_id,
`ifdef ARB_STATS_EN
  output logic [NUM_SRC*STAT_W-1:0] pkt_cnt,
  output logic                      beat_stall,
`endif
  output logic                      busy
);

  arb_state_e       state_r;
  logic [SID_W-1:0] rr_ptr_r;
  logic [SID_W-1:0] grant_r;
  logic             busy_r;
  logic             pick_found_s;
  logic [SID_W-1:0] pick_idx_s;
  logic             last_accept_s;

  rr_priority_pick #(
    .NUM_SRC (NUM_SRC),
    .SID_W   (SID_W)
  ) u_pick (
    .req   (s_axis_tvalid),
    .ptr   (rr_ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Zero-latency pass-through of the granted source while transferring; everything idle otherwise.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_r == XFER) begin
      m_axis_tvalid          = s_axis_tvalid[grant_r];
      m_axis_tdata           = s_axis_tdata[grant_r*DATA_W +: DATA_W];
      m_axis_tkeep           = s_axis_tkeep[grant_r*KEEP_W +: KEEP_W];
      m_axis_tlast           = s_axis_tlast[grant_r];
      s_axis_tready[grant_r] = m_axis_tready;
    end else begin
      m_axis_tvalid = 1'b0;
    end
  end

  assign last_accept_s = (state_r == XFER) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Arbitration FSM: requests only matter in IDLE; the grant is released solely by an accepted tlast.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_r  <= IDLE;
      rr_ptr_r <= SID_W'(NUM_SRC - 1);
      grant_r  <= '0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            grant_r <= pick_idx_s;
            busy_r  <= 1'b1;
            state_r <= XFER;
          end
        end
        XFER: begin
          if (last_accept_s) begin
            rr_ptr_r <= grant_r;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_id = grant_r;
  assign busy     = busy_r;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt_r [NUM_SRC];
  logic              stall_r;

  // Saturating per-source packet counters and a one-cycle-delayed backpressure flag.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_r[i] <= '0;
      end
      stall_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (last_accept_s && (grant_r == SID_W'(i)) && (cnt_r[i] != {STAT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + STAT_W'(1);
        end
      end
      stall_r <= m_axis_tvalid & ~m_axis_tready;
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
    assign pkt_cnt[gi*STAT_W +: STAT_W] = cnt_r[gi];
  end
  assign beat_stall = stall_r;
`endif

endmodule
